// File: rtl/trdb_branch_map_decoder.sv
// Unpacks a trace packet's branch map into a per-branch taken/not-taken stream, then its address.
// Latency: first branch or address is valid one cycle after the packet is accepted.
// Backpressure: one packet in flight; outputs hold while br_ready_i/addr_ready_i are low.
module trdb_branch_map_decoder #(
    parameter int BRANCH_MAP_LEN = 30,
    parameter int XLEN           = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      pkt_valid_i,
    output logic                      pkt_ready_o,
    input  logic [1:0]                format_i,
    input  logic [4:0]                branches_i,
    input  logic [BRANCH_MAP_LEN-1:0] branch_map_i,
    input  logic [XLEN-1:0]           address_i,
    output logic                      br_valid_o,
    input  logic                      br_ready_i,
    output logic                      br_taken_o,
    output logic                      br_last_o,
    output logic                      addr_valid_o,
    input  logic                      addr_ready_i,
    output logic [XLEN-1:0]           addr_o,
    output logic [1:0]                addr_fmt_o,
    output logic                      err_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BRANCH = 2'd1;
    localparam logic [1:0] S_ADDR   = 2'd2;

    localparam logic [1:0] FMT_OPT_EXT = 2'd0;
    localparam logic [1:0] FMT_DIFF    = 2'd1;
    localparam logic [1:0] FMT_ADDR    = 2'd2;
    localparam logic [1:0] FMT_SYNC    = 2'd3;

    localparam logic [4:0] MAP_LAST_IDX = 5'(BRANCH_MAP_LEN - 1);
    localparam logic [5:0] MAP_LEN_W    = 6'(BRANCH_MAP_LEN);

    logic [1:0]                r_state;
    logic [4:0]                r_idx;
    logic [4:0]                r_last_idx;
    logic                      r_has_addr;
    logic [BRANCH_MAP_LEN-1:0] r_map;
    logic [XLEN-1:0]           r_addr;
    logic [1:0]                r_fmt;
    logic                      r_err;

    logic                      w_map_full;
    logic                      w_over;
    logic [4:0]                w_last_idx_in;
    logic                      w_br_at_last;

    // branches_i == 0 means the map is completely full and no address follows.
    assign w_map_full    = (branches_i == 5'd0);
    assign w_over        = ({1'b0, branches_i} > MAP_LEN_W);
    assign w_last_idx_in = (w_map_full || w_over) ? MAP_LAST_IDX : (branches_i - 5'd1);
    assign w_br_at_last  = (r_idx == r_last_idx);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_idx      <= 5'd0;
            r_last_idx <= 5'd0;
            r_has_addr <= 1'b0;
            r_map      <= '0;
            r_addr     <= '0;
            r_fmt      <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pkt_valid_i) begin
                        r_fmt  <= format_i;
                        r_map  <= branch_map_i;
                        r_addr <= address_i;
                        r_idx  <= 5'd0;
                        case (format_i)
                            FMT_DIFF: begin
                                r_last_idx <= w_last_idx_in;
                                r_has_addr <= !w_map_full;
                                r_err      <= w_over;
                                r_state    <= S_BRANCH;
                            end
                            FMT_ADDR, FMT_SYNC: begin
                                r_has_addr <= 1'b1;
                                r_state    <= S_ADDR;
                            end
                            FMT_OPT_EXT: begin
                                r_err <= 1'b1;
                            end
                            default: begin
                                r_err <= 1'b1;
                            end
                        endcase
                    end
                end
                S_BRANCH: begin
                    if (br_ready_i) begin
                        if (w_br_at_last) begin
                            r_idx   <= 5'd0;
                            r_state <= r_has_addr ? S_ADDR : S_IDLE;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (addr_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by reset so it is low for the whole time reset is held.
    assign pkt_ready_o  = (r_state == S_IDLE) && !rst_i;
    assign br_valid_o   = (r_state == S_BRANCH);
    assign br_taken_o   = br_valid_o && !r_map[r_idx];
    assign br_last_o    = br_valid_o && w_br_at_last;
    assign addr_valid_o = (r_state == S_ADDR);
    assign addr_o       = r_addr;
    assign addr_fmt_o   = r_fmt;
    assign err_o        = r_err;

endmodule

// File: tb/tb_trdb_branch_map_decoder.sv
// Directed vector table plus hand-written reset and random-backpressure sequences.
module tb_trdb_branch_map_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [1:0]  format_i;
    logic [4:0]  branches_i;
    logic [29:0] branch_map_i;
    logic [31:0] address_i;
    logic        br_valid_o;
    logic        br_ready_i;
    logic        br_taken_o;
    logic        br_last_o;
    logic        addr_valid_o;
    logic        addr_ready_i;
    logic [31:0] addr_o;
    logic [1:0]  addr_fmt_o;
    logic        err_o;

    trdb_branch_map_decoder #(.BRANCH_MAP_LEN(30), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
        .format_i(format_i), .branches_i(branches_i),
        .branch_map_i(branch_map_i), .address_i(address_i),
        .br_valid_o(br_valid_o), .br_ready_i(br_ready_i),
        .br_taken_o(br_taken_o), .br_last_o(br_last_o),
        .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
        .addr_o(addr_o), .addr_fmt_o(addr_fmt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  fmt;
        logic [4:0]  br;
        logic [29:0] map;
        logic [31:0] addr;
        int          exp_n;
        bit          exp_has;
        bit          exp_err;
        logic [29:0] exp_taken;
        int          rdy_mode;   // 0 always ready, 1 random, 2 addr stalled 5 cycles
    } vec_t;

    vec_t vecs[9];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] f, input logic [4:0] b, input logic [29:0] m,
                                  output int n, output bit has, output bit err,
                                  output logic [29:0] tk);
        tk = ~m;
        n = 0; has = 1'b0; err = 1'b0;
        if (f == 2'd0) begin
            err = 1'b1;
        end else if (f == 2'd1) begin
            if (b == 5'd0) begin
                n = 30;
            end else if (int'(b) > 30) begin
                n = 30; has = 1'b1; err = 1'b1;
            end else begin
                n = int'(b); has = 1'b1;
            end
        end else begin
            has = 1'b1;
        end
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_pkt(input vec_t v);
        int          nb;
        int          cyc;
        int          stalls;
        bit          ga;
        bit          done;
        bit          br_stall;
        bit          ad_stall;
        logic        p_taken;
        logic        p_last;
        logic [31:0] p_addr;
        nb = 0; cyc = 0; stalls = 0; ga = 0;
        br_stall = 0; ad_stall = 0; p_taken = 0; p_last = 0; p_addr = 0;
        check("pkt_ready_before_accept", pkt_ready_o, 1);
        format_i = v.fmt; branches_i = v.br; branch_map_i = v.map; address_i = v.addr;
        pkt_valid_i = 1'b1;
        @(posedge clk_i); #1;
        pkt_valid_i = 1'b0;
        check("err_pulse", err_o, v.exp_err);
        done = (v.exp_n == 0) && !v.exp_has;
        while (!done && cyc < 400) begin
            br_ready_i   = (v.rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            addr_ready_i = (v.rdy_mode == 1) ? 1'($urandom_range(0, 1)) :
                           (v.rdy_mode == 2) ? (stalls >= 5) : 1'b1;
            #0;
            check("dual_valid", br_valid_o && addr_valid_o, 0);
            check("pkt_ready_busy", pkt_ready_o, 0);
            if (br_stall) begin
                check("br_hold_valid", br_valid_o, 1);
                check("br_hold_taken", br_taken_o, p_taken);
                check("br_hold_last", br_last_o, p_last);
            end
            if (ad_stall) begin
                check("addr_hold_valid", addr_valid_o, 1);
                check("addr_hold_value", addr_o, p_addr);
            end
            br_stall = 0; ad_stall = 0;
            if (br_valid_o) begin
                if (br_ready_i) begin
                    if (nb >= v.exp_n) begin
                        check("extra_branch", nb, v.exp_n);
                        done = 1;
                    end else begin
                        check("br_taken", br_taken_o, v.exp_taken[nb]);
                        check("br_last", br_last_o, (nb == v.exp_n - 1));
                        nb++;
                    end
                end else begin
                    br_stall = 1; p_taken = br_taken_o; p_last = br_last_o;
                end
            end
            if (addr_valid_o) begin
                if (addr_ready_i) begin
                    check("addr_expected", v.exp_has && !ga, 1);
                    check("addr_after_branches", nb, v.exp_n);
                    check("addr_value", addr_o, v.addr);
                    check("addr_fmt", addr_fmt_o, v.fmt);
                    ga = 1;
                    if (!v.exp_has) done = 1;
                end else begin
                    ad_stall = 1; p_addr = addr_o; stalls++;
                end
            end
            if (nb == v.exp_n && ga == v.exp_has) done = 1;
            @(posedge clk_i); #1;
            cyc++;
        end
        check("pkt_complete_in_budget", done, 1);
        if (v.rdy_mode == 2) check("addr_stall_cycles", stalls, 5);
        br_ready_i = 1'b0; addr_ready_i = 1'b0;
        check("idle_br_valid", br_valid_o, 0);
        check("idle_addr_valid", addr_valid_o, 0);
        check("idle_pkt_ready", pkt_ready_o, 1);
        @(posedge clk_i); #1;
        check("err_single_cycle", err_o, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   hs;
        int   cyc;
        int   seen;

        //            fmt   br     map             addr           n   has err taken           mode
        vecs[0] = '{2'd1, 5'd3,  30'b010,        32'h8000_0100, 3,  1, 0, 30'b101,        0};
        vecs[1] = '{2'd1, 5'd0,  30'h3FFF_FFFF,  32'h0000_0FF0, 30, 0, 0, 30'h0,          0};
        vecs[2] = '{2'd2, 5'd7,  30'h0000_00AA,  32'h0000_1234, 0,  1, 0, 30'h0,          2};
        vecs[3] = '{2'd0, 5'd5,  30'h0000_0003,  32'h0000_5555, 0,  0, 1, 30'h0,          0};
        vecs[4] = '{2'd1, 5'd31, 30'h0,          32'hDEAD_BEEF, 30, 1, 1, 30'h3FFF_FFFF,  0};
        vecs[5] = '{2'd3, 5'd12, 30'h1234_5678,  32'hCAFE_0000, 0,  1, 0, 30'h0,          1};
        vecs[6] = '{2'd1, 5'd1,  30'h3FFF_FFFE,  32'h0000_0004, 1,  1, 0, 30'h1,          0};
        vecs[7] = '{2'd1, 5'd30, 30'h2AAA_AAAA,  32'h7000_0000, 30, 1, 0, 30'h1555_5555,  1};
        vecs[8] = '{2'd1, 5'd5,  30'b10011,      32'h0000_00C0, 5,  1, 0, 30'hC,          1};

        rst_i = 1'b1; pkt_valid_i = 1'b0; format_i = 2'd0; branches_i = 5'd0;
        branch_map_i = '0; address_i = '0; br_ready_i = 1'b0; addr_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_pkt_ready", pkt_ready_o, 0);
        check("rst_br_valid", br_valid_o, 0);
        check("rst_addr_valid", addr_valid_o, 0);
        check("rst_br_taken", br_taken_o, 0);
        check("rst_br_last", br_last_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_addr_fmt", addr_fmt_o, 0);
        check("rst_err", err_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("pkt_ready_after_rst", pkt_ready_o, 1);

        for (int i = 0; i < 9; i++) begin
            run_pkt(vecs[i]);
        end

        // Reset after the fourth branch handshake of a ten-branch packet.
        format_i = 2'd1; branches_i = 5'd10; branch_map_i = '0; address_i = 32'h0000_0055;
        pkt_valid_i = 1'b1;
        @(posedge clk_i); #1;
        pkt_valid_i = 1'b0;
        br_ready_i = 1'b1;
        hs = 0; cyc = 0;
        while (hs < 4 && cyc < 50) begin
            if (br_valid_o && br_ready_i) hs++;
            @(posedge clk_i); #1;
            cyc++;
        end
        check("midrst_handshakes", hs, 4);
        rst_i = 1'b1; br_ready_i = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_br_valid", br_valid_o, 0);
        check("midrst_addr_valid", addr_valid_o, 0);
        check("midrst_pkt_ready", pkt_ready_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_pkt_ready_release", pkt_ready_o, 1);
        br_ready_i = 1'b1; addr_ready_i = 1'b1;
        seen = 0;
        repeat (20) begin
            if (br_valid_o || addr_valid_o) seen++;
            @(posedge clk_i); #1;
        end
        check("midrst_no_output", seen, 0);
        br_ready_i = 1'b0; addr_ready_i = 1'b0;

        // Random packets under random backpressure.
        for (int p = 0; p < 1000; p++) begin
            v.fmt      = 2'($urandom_range(0, 3));
            v.br       = 5'($urandom_range(0, 31));
            v.map      = 30'($urandom());
            v.addr     = $urandom();
            v.rdy_mode = 1;
            model(v.fmt, v.br, v.map, v.exp_n, v.exp_has, v.exp_err, v.exp_taken);
            run_pkt(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
